// File: rtl/bus_arbiter_if.sv
// Signal bundle between the two bus masters and the bus arbiter: requests, slave selects and
// split flags toward the arbiter; grants, split status and mux selects back from it.
interface bus_arbiter_if #(
  parameter int NUM_SLAVES = 3,
  parameter int SSEL_W     = 2
);
  logic                  m1_request;
  logic [SSEL_W-1:0]     m1_slave_sel;
  logic                  m2_request;
  logic [SSEL_W-1:0]     m2_slave_sel;
  logic [NUM_SLAVES-1:0] split_en;
  logic                  m1_grant;
  logic                  m2_grant;
  logic                  m1_split;
  logic                  m2_split;
  logic                  msel;
  logic [SSEL_W-1:0]     ssel;
  logic                  bus_busy;
  logic                  decode_err;

  // Requesting side: masters plus the split flags coming back from the slave ports.
  modport master (
    output m1_request, m1_slave_sel, m2_request, m2_slave_sel, split_en,
    input  m1_grant, m2_grant, m1_split, m2_split, msel, ssel, bus_busy, decode_err
  );

  // Arbiter side.
  modport slave (
    input  m1_request, m1_slave_sel, m2_request, m2_slave_sel, split_en,
    output m1_grant, m2_grant, m1_split, m2_split, msel, ssel, bus_busy, decode_err
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter with split-transaction parking and one turnaround cycle per release.
// Define ARB_ROUND_ROBIN_EN to break simultaneous-request ties toward the master not granted last.
module bus_arbiter #(
  parameter int NUM_SLAVES = 3,
  parameter int SSEL_W     = 2
) (
  input  logic         clk,
  input  logic         reset,
  bus_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, GRANT, SPLIT_IDLE, SPLIT_GRANT} state_t;

  state_t                state_q, state_n;
  logic                  owner_q, owner_n;   // current/last owner, drives msel
  logic [SSEL_W-1:0]     ssel_q, ssel_n;
  logic                  pk_m_q, pk_m_n;
  logic [SSEL_W-1:0]     pk_s_q, pk_s_n;
  logic                  resume_q, resume_n;
  logic [NUM_SLAVES-1:0] split_q;
  logic [1:0]            req_q;

  logic                  m1_grant_q, m2_grant_q, m1_split_q, m2_split_q;
  logic                  busy_q, derr_q;
  logic                  m1_grant_n, m2_grant_n, m1_split_n, m2_split_n, derr_n;

  logic [1:0]            req, sel_ok, valid;
  logic [SSEL_W-1:0]     sel [2];
  logic                  pick, other, fall, tie_pick, owned_n, parked_n;

  assign req    = {bus.m2_request, bus.m1_request};
  assign sel[0] = bus.m1_slave_sel;
  assign sel[1] = bus.m2_slave_sel;
  assign sel_ok = {int'(sel[1]) < NUM_SLAVES, int'(sel[0]) < NUM_SLAVES};
  assign valid  = req & sel_ok;

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else if ((m1_grant_n || m2_grant_n) && !(m1_grant_q || m2_grant_q)) begin
      last_q <= owner_n;
    end
  end

  assign tie_pick = ~last_q;
`else
  assign tie_pick = 1'b0;
`endif

  assign pick  = (valid == 2'b11) ? tie_pick : valid[1];
  assign other = ~pk_m_q;
  // Resume is the falling edge of the parked slave's split flag.
  assign fall  = split_q[pk_s_q] & ~bus.split_en[pk_s_q];

  // NOTE: every combinational output gets a default before the case so no latch is inferred.
  always_comb begin
    state_n  = state_q;
    owner_n  = owner_q;
    ssel_n   = ssel_q;
    pk_m_n   = pk_m_q;
    pk_s_n   = pk_s_q;
    resume_n = resume_q;
    case (state_q)
      IDLE: begin
        if (|valid) begin
          state_n = GRANT;
          owner_n = pick;
          ssel_n  = sel[pick];
        end
      end
      GRANT: begin
        if (!req[owner_q]) begin
          state_n = IDLE;
        end else if (bus.split_en[ssel_q]) begin
          state_n  = SPLIT_IDLE;
          pk_m_n   = owner_q;
          pk_s_n   = ssel_q;
          resume_n = 1'b0;
        end
      end
      SPLIT_IDLE: begin
        if (!req[pk_m_q]) begin
          state_n  = IDLE;
          resume_n = 1'b0;
        end else if (resume_q || fall) begin
          state_n  = GRANT;
          owner_n  = pk_m_q;
          ssel_n   = pk_s_q;
          resume_n = 1'b0;
        end else if (valid[other] && sel[other] != pk_s_q) begin
          state_n = SPLIT_GRANT;
          owner_n = other;
          ssel_n  = sel[other];
        end
      end
      SPLIT_GRANT: begin
        if (!req[pk_m_q]) begin
          state_n  = req[owner_q] ? GRANT : IDLE;
          resume_n = 1'b0;
        end else if (!req[owner_q]) begin
          state_n  = SPLIT_IDLE;
          resume_n = resume_q | fall;
        end else if (fall) begin
          resume_n = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign owned_n    = (state_n == GRANT) || (state_n == SPLIT_GRANT);
  assign parked_n   = (state_n == SPLIT_IDLE) || (state_n == SPLIT_GRANT);
  assign m1_grant_n = owned_n && !owner_n;
  assign m2_grant_n = owned_n && owner_n;
  assign m1_split_n = parked_n && !pk_m_n;
  assign m2_split_n = parked_n && pk_m_n;
  assign derr_n     = |(req & ~req_q & ~sel_ok);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      ssel_q     <= '0;
      pk_m_q     <= 1'b0;
      pk_s_q     <= '0;
      resume_q   <= 1'b0;
      split_q    <= '0;
      req_q      <= '0;
      m1_grant_q <= 1'b0;
      m2_grant_q <= 1'b0;
      m1_split_q <= 1'b0;
      m2_split_q <= 1'b0;
      busy_q     <= 1'b0;
      derr_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      owner_q    <= owner_n;
      ssel_q     <= ssel_n;
      pk_m_q     <= pk_m_n;
      pk_s_q     <= pk_s_n;
      resume_q   <= resume_n;
      split_q    <= bus.split_en;
      req_q      <= req;
      m1_grant_q <= m1_grant_n;
      m2_grant_q <= m2_grant_n;
      m1_split_q <= m1_split_n;
      m2_split_q <= m2_split_n;
      busy_q     <= owned_n;
      derr_q     <= derr_n;
    end
  end

  assign bus.m1_grant   = m1_grant_q;
  assign bus.m2_grant   = m2_grant_q;
  assign bus.m1_split   = m1_split_q;
  assign bus.m2_split   = m2_split_q;
  assign bus.msel       = owner_q;
  assign bus.ssel       = ssel_q;
  assign bus.bus_busy   = busy_q;
  assign bus.decode_err = derr_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: each driven cycle queues the expected registered outputs,
// which are popped and compared one clock later.
module tb_bus_arbiter;

  typedef struct {
    string      tag;
    logic [8:0] v;
  } exp_t;

  logic clk;
  logic reset;
  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  logic w;

  bus_arbiter_if #(.NUM_SLAVES(3), .SSEL_W(2)) bus ();

  bus_arbiter #(.NUM_SLAVES(3), .SSEL_W(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector: g1 g2 s1 s2 msel ssel[1:0] busy derr
  function automatic logic [8:0] obs();
    return {bus.m1_grant, bus.m2_grant, bus.m1_split, bus.m2_split, bus.msel,
            bus.ssel, bus.bus_busy, bus.decode_err};
  endfunction

  function automatic logic [8:0] ex(input logic g1, input logic g2, input logic s1,
                                    input logic s2, input logic ms, input logic [1:0] ss,
                                    input logic de);
    return {g1, g2, s1, s2, ms, ss, g1 | g2, de};
  endfunction

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %b expected %b (g1 g2 s1 s2 msel ssel busy derr)", tag, got, want);
  endtask

  task automatic drive(input logic r1, input logic [1:0] s1, input logic r2,
                       input logic [1:0] s2, input logic [2:0] sp);
    bus.m1_request   = r1;
    bus.m1_slave_sel = s1;
    bus.m2_request   = r2;
    bus.m2_slave_sel = s2;
    bus.split_en     = sp;
  endtask

  // One bus cycle: drive inputs, queue the outputs expected after the edge, then compare.
  task automatic cyc(input string tag, input logic r1, input logic [1:0] s1, input logic r2,
                     input logic [1:0] s2, input logic [2:0] sp, input logic [8:0] want);
    exp_t e;
    @(negedge clk);
    drive(r1, s1, r2, s2, sp);
    sb.push_back('{tag, want});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check(e.tag, obs(), e.v);
  endtask

  initial begin
    reset = 1'b0;
    drive(0, 0, 0, 0, 3'b000);
    repeat (2) @(negedge clk);
    check("reset_state", obs(), 9'b0);
    reset = 1'b1;

    // Asynchronous reset in the middle of a grant.
    cyc("t1_pre",        1, 0, 0, 0, 3'b000, ex(1, 0, 0, 0, 0, 2'd0, 0));
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", obs(), 9'b0);
    drive(0, 0, 0, 0, 3'b000);
    @(negedge clk);
    reset = 1'b1;
    cyc("t1_idle",       0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, 0, 2'd0, 0));

    // Single M2 request on slave 1.
    cyc("t1_grant",      0, 0, 1, 1, 3'b000, ex(0, 1, 0, 0, 1, 2'd1, 0));
    cyc("t1_hold",       0, 0, 1, 1, 3'b000, ex(0, 1, 0, 0, 1, 2'd1, 0));
    cyc("t1_release",    0, 0, 0, 1, 3'b000, ex(0, 0, 0, 0, 1, 2'd1, 0));

    // Tie, then turnaround before the loser is served.
    cyc("t2_tie",        1, 0, 1, 2, 3'b000, ex(1, 0, 0, 0, 0, 2'd0, 0));
    cyc("t2_turn",       0, 0, 1, 2, 3'b000, ex(0, 0, 0, 0, 0, 2'd0, 0));
    cyc("t2_m2",         0, 0, 1, 2, 3'b000, ex(0, 1, 0, 0, 1, 2'd2, 0));
    cyc("t2_idle",       0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, 1, 2'd2, 0));

    // Repeated ties: fixed priority always M1, round robin alternates M1, M2, M1.
    for (int k = 0; k < 3; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      w = k[0];
`else
      w = 1'b0;
`endif
      cyc("t2_rep_tie",  1, 0, 1, 2, 3'b000, ex(!w, w, 0, 0, w, w ? 2'd2 : 2'd0, 0));
      cyc("t2_rep_idle", 0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, w, w ? 2'd2 : 2'd0, 0));
    end

    // Split on slave 2, M2 served meanwhile, resume while M2 holds the bus.
    cyc("t3_grant",      1, 2, 0, 0, 3'b000, ex(1, 0, 0, 0, 0, 2'd2, 0));
    cyc("t3_park",       1, 2, 0, 0, 3'b100, ex(0, 0, 1, 0, 0, 2'd2, 0));
    cyc("t3_m2",         1, 2, 1, 0, 3'b100, ex(0, 1, 1, 0, 1, 2'd0, 0));
    cyc("t3_resume",     1, 2, 1, 0, 3'b000, ex(0, 1, 1, 0, 1, 2'd0, 0));
    cyc("t3_owner_split",1, 2, 1, 0, 3'b001, ex(0, 1, 1, 0, 1, 2'd0, 0));
    cyc("t3_rel",        1, 2, 0, 0, 3'b000, ex(0, 0, 1, 0, 1, 2'd0, 0));
    cyc("t3_regrant",    1, 2, 1, 0, 3'b000, ex(1, 0, 0, 0, 0, 2'd2, 0));
    cyc("t3_m1_rel",     0, 2, 1, 0, 3'b000, ex(0, 0, 0, 0, 0, 2'd2, 0));
    cyc("t3_m2_after",   0, 2, 1, 0, 3'b000, ex(0, 1, 0, 0, 1, 2'd0, 0));
    cyc("t3_idle",       0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, 1, 2'd0, 0));

    // M2 blocked on the parked slave until resume.
    cyc("t4_grant",      1, 1, 0, 0, 3'b000, ex(1, 0, 0, 0, 0, 2'd1, 0));
    cyc("t4_park",       1, 1, 0, 0, 3'b010, ex(0, 0, 1, 0, 0, 2'd1, 0));
    for (int i = 0; i < 10; i++)
      cyc("t4_blocked",  1, 1, 1, 1, 3'b010, ex(0, 0, 1, 0, 0, 2'd1, 0));
    cyc("t4_regrant",    1, 1, 1, 1, 3'b000, ex(1, 0, 0, 0, 0, 2'd1, 0));
    cyc("t4_other_split",1, 1, 1, 1, 3'b101, ex(1, 0, 0, 0, 0, 2'd1, 0));
    cyc("t4_rel",        0, 1, 1, 1, 3'b000, ex(0, 0, 0, 0, 0, 2'd1, 0));
    cyc("t4_m2",         0, 1, 1, 1, 3'b000, ex(0, 1, 0, 0, 1, 2'd1, 0));
    cyc("t4_idle",       0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, 1, 2'd1, 0));

    // Release and split in the same cycle: release wins.
    cyc("t5_grant",      1, 0, 0, 0, 3'b000, ex(1, 0, 0, 0, 0, 2'd0, 0));
    cyc("t5_rel_wins",   0, 0, 0, 0, 3'b001, ex(0, 0, 0, 0, 0, 2'd0, 0));
    cyc("t5_idle",       0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, 0, 2'd0, 0));
    cyc("t5_idle_grant", 0, 0, 1, 0, 3'b000, ex(0, 1, 0, 0, 1, 2'd0, 0));
    cyc("t5_idle2",      0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, 1, 2'd0, 0));

    // Invalid slave select: one pulse per request, never granted, M1 unaffected.
    cyc("t5_derr",       0, 0, 1, 3, 3'b000, ex(0, 0, 0, 0, 1, 2'd0, 1));
    cyc("t5_m1_ok",      1, 0, 1, 3, 3'b000, ex(1, 0, 0, 0, 0, 2'd0, 0));
    cyc("t5_m1_rel",     0, 0, 1, 3, 3'b000, ex(0, 0, 0, 0, 0, 2'd0, 0));
    cyc("t5_never",      0, 0, 1, 3, 3'b000, ex(0, 0, 0, 0, 0, 2'd0, 0));
    cyc("t5_drop",       0, 0, 0, 3, 3'b000, ex(0, 0, 0, 0, 0, 2'd0, 0));
    cyc("t5_derr2",      0, 0, 1, 3, 3'b000, ex(0, 0, 0, 0, 0, 2'd0, 1));
    cyc("t5_derr2_end",  0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, 0, 2'd0, 0));

    // Parked master abandons; the later split_en fall must not regrant it.
    cyc("t5_grant2",     1, 2, 0, 0, 3'b000, ex(1, 0, 0, 0, 0, 2'd2, 0));
    cyc("t5_park",       1, 2, 0, 0, 3'b100, ex(0, 0, 1, 0, 0, 2'd2, 0));
    cyc("t5_abandon",    0, 2, 0, 0, 3'b100, ex(0, 0, 0, 0, 0, 2'd2, 0));
    cyc("t5_no_resume",  0, 2, 0, 0, 3'b000, ex(0, 0, 0, 0, 0, 2'd2, 0));
    cyc("t5_final",      0, 0, 0, 0, 3'b000, ex(0, 0, 0, 0, 0, 2'd2, 0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
